// File: rtl/led_scan_sequencer_if.sv
// Framebuffer read port and LED driver front end.
// Master side is the scan sequencer.
interface led_scan_sequencer_if #(
  parameter int COLS = 8,
  parameter int ROWS = 8
);
  localparam int RW = $clog2(ROWS);

  logic            rd_en;
  logic [RW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic            din;
  logic            dclk;
  logic            strobe;
  logic            blank;
  logic [RW-1:0]   row_sel;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output din,
    output dclk,
    output strobe,
    output blank,
    output row_sel
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  din,
    input  dclk,
    input  strobe,
    input  blank,
    input  row_sel
  );
endinterface

// File: rtl/led_scan_sequencer.sv
// LED matrix row-scan sequencer: fetch, shift, latch, blank.
// Optional frame counter enabled by macro FRAME_COUNT_EN.
module led_scan_sequencer #(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int DCLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:0] blank_time,
  led_scan_sequencer_if.master bus,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);
  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(COLS + 1);
  localparam int DW = $clog2(2 * DCLK_DIV + 1);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(COLS - 1);
  localparam logic [DW-1:0] HI_START = DW'(DCLK_DIV - 1);
  localparam logic [DW-1:0] LAST_HI  = DW'(2 * DCLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_BLANK
  } state_t;

  state_t          r_state, w_state;
  logic [RW-1:0]   r_row, w_row;
  logic [COLS-1:0] r_shreg, w_shreg;
  logic [BW-1:0]   r_bit, w_bit;
  logic [DW-1:0]   r_div, w_div;
  logic [4:0]      r_bt, w_bt;
  logic [4:0]      r_bcnt, w_bcnt;

  logic            r_rd_en, w_rd_en;
  logic [RW-1:0]   r_rd_addr, w_rd_addr;
  logic            r_din, w_din;
  logic            r_dclk, w_dclk;
  logic            r_strobe, w_strobe;
  logic            r_blank, w_blank;
  logic [RW-1:0]   r_row_sel, w_row_sel;
  logic            r_busy, w_busy;
  logic            r_frame_done, w_frame_done;
  logic            w_row_end;

  always_comb begin
    w_state      = r_state;
    w_row        = r_row;
    w_shreg      = r_shreg;
    w_bit        = r_bit;
    w_div        = r_div;
    w_bt         = r_bt;
    w_bcnt       = r_bcnt;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_rd_addr;
    w_din        = r_din;
    w_dclk       = r_dclk;
    w_strobe     = 1'b0;
    w_blank      = r_blank;
    w_row_sel    = r_row_sel;
    w_frame_done = 1'b0;
    w_row_end    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_blank = 1'b1;
        w_dclk  = 1'b0;
        if (enable) begin
          w_state   = S_FETCH;
          w_row     = '0;
          w_rd_en   = 1'b1;
          w_rd_addr = '0;
        end
      end
      S_FETCH: begin
        w_state = S_LOAD;
      end
      S_LOAD: begin
        w_shreg = bus.rd_data;
        w_bit   = '0;
        w_div   = '0;
        w_din   = bus.rd_data[COLS-1];
        w_state = S_SHIFT;
      end
      S_SHIFT: begin
        w_div = r_div + 1'b1;
        if (r_div == HI_START) begin
          w_dclk = 1'b1;
        end
        if (r_div == LAST_HI) begin
          w_dclk = 1'b0;
          w_div  = '0;
          w_bit  = r_bit + 1'b1;
          if (r_bit == LAST_BIT) begin
            w_state  = S_LATCH;
            w_strobe = 1'b1;
            w_blank  = 1'b1;
          end else begin
            w_shreg = r_shreg << 1;
            w_din   = r_shreg[COLS-2];
          end
        end
      end
      S_LATCH: begin
        w_row_sel = r_row;
        w_bt      = blank_time;
        w_bcnt    = '0;
        if (blank_time == 5'd0) begin
          w_row_end = 1'b1;
        end else begin
          w_state = S_BLANK;
        end
      end
      S_BLANK: begin
        w_bcnt = r_bcnt + 1'b1;
        if (r_bcnt == r_bt - 5'd1) begin
          w_row_end = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Row end: light the latched row, advance, then rerun or park.
    if (w_row_end) begin
      w_frame_done = (r_row == LAST_ROW);
      w_row        = (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
      if (enable) begin
        w_state   = S_FETCH;
        w_rd_en   = 1'b1;
        w_rd_addr = w_row;
        w_blank   = 1'b0;
      end else begin
        w_state = S_IDLE;
        w_blank = 1'b1;
      end
    end

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_shreg      <= '0;
      r_bit        <= '0;
      r_div        <= '0;
      r_bt         <= '0;
      r_bcnt       <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_din        <= 1'b0;
      r_dclk       <= 1'b0;
      r_strobe     <= 1'b0;
      r_blank      <= 1'b1;
      r_row_sel    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_row        <= w_row;
      r_shreg      <= w_shreg;
      r_bit        <= w_bit;
      r_div        <= w_div;
      r_bt         <= w_bt;
      r_bcnt       <= w_bcnt;
      r_rd_en      <= w_rd_en;
      r_rd_addr    <= w_rd_addr;
      r_din        <= w_din;
      r_dclk       <= w_dclk;
      r_strobe     <= w_strobe;
      r_blank      <= w_blank;
      r_row_sel    <= w_row_sel;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
    end
  end

`ifdef FRAME_COUNT_EN
  logic [7:0] r_frame_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_count <= 8'h00;
    end else if (w_frame_done) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = 8'h00;
`endif

  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;
  assign bus.din     = r_din;
  assign bus.dclk    = r_dclk;
  assign bus.strobe  = r_strobe;
  assign bus.blank   = r_blank;
  assign bus.row_sel = r_row_sel;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
endmodule
